// File: rtl/ysyx_22041207_mul_issue_pkg.sv
// Shared definitions for the multiply issue unit: op encodings, FSM states
// and default widths.
package ysyx_22041207_mul_issue_pkg;

   localparam int XLEN_DEF = 64;
   localparam int TAGW_DEF = 5;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_MULW   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_FIX   = 3'd3,
      S_OUT   = 3'd4
   } state_t;

endpackage

// File: rtl/ysyx_22041207_mul_fixup.sv
// Sign fix-up and result selection for the 2*XLEN unsigned product.
// The product is computed from operand magnitudes, so a negative result is
// recovered by negating the full-width product before picking a half.
module ysyx_22041207_mul_fixup
   import ysyx_22041207_mul_issue_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [2*XLEN-1:0] prod,
   input  logic              neg,
   input  logic [2:0]        op,
   output logic [XLEN-1:0]   res
);

   logic [2*XLEN-1:0] p;

   assign p = neg ? -prod : prod;

   // Pick the half (or sign-extended word) the op asks for
   always_comb begin
      res = p[XLEN-1:0];
      case (op)
         OP_MULH, OP_MULHSU, OP_MULHU: res = p[2*XLEN-1:XLEN];
         OP_MULW:                      res = {{(XLEN-32){p[31]}}, p[31:0]};
         default:                      ;
      endcase
   end

endmodule

// File: rtl/ysyx_22041207_mul_issue.sv
// Execute-stage front end for the iterative multiplier: decode, operand
// magnitude conversion, job issue, product capture, fix-up and writeback.
// Optional macro YSYX_22041207_MUL_ZERO_BYPASS_EN: a zero effective operand
// skips the multiplier and goes straight to OUT with a zero result.
module ysyx_22041207_mul_issue
   import ysyx_22041207_mul_issue_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int TAGW = TAGW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_src1,
   input  logic [XLEN-1:0] req_src2,
   input  logic [TAGW-1:0] req_rd,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [XLEN-1:0] wb_data,
   output logic [TAGW-1:0] wb_rd,
   output logic            busy,
   output logic            mul_valid,
   output logic            mul_flush,
   output logic [XLEN-1:0] mul_multiplicand,
   output logic [XLEN-1:0] mul_multiplier,
   input  logic            mul_ready,
   input  logic            mul_out_valid,
   input  logic [XLEN-1:0] mul_res_hi,
   input  logic [XLEN-1:0] mul_res_lo
);

   state_t state_q, state_d;

   logic [2:0]        op_q;
   logic [TAGW-1:0]   rd_q;
   logic              neg_q;
   logic [XLEN-1:0]   mcand_q, mplier_q;
   logic [2*XLEN-1:0] prod_q;
   logic [XLEN-1:0]   wb_data_q;
   logic [TAGW-1:0]   wb_rd_q;

   logic [2:0]      op_n;
   logic            sgn1, sgn2, neg_d;
   logic [XLEN-1:0] opa_eff, opb_eff, mag1, mag2;
   logic            accept, bypass_hit;
   logic [XLEN-1:0] fix_res;

   // Ops 5-7 are reserved and behave as MUL
   assign op_n = (req_op > OP_MULW) ? OP_MUL : req_op;

   // MULW works on zero-extended low words and is never negated
   assign opa_eff = (op_n == OP_MULW) ? {{(XLEN-32){1'b0}}, req_src1[31:0]} : req_src1;
   assign opb_eff = (op_n == OP_MULW) ? {{(XLEN-32){1'b0}}, req_src2[31:0]} : req_src2;

   assign sgn1 = (op_n == OP_MUL || op_n == OP_MULH || op_n == OP_MULHSU) && req_src1[XLEN-1];
   assign sgn2 = (op_n == OP_MUL || op_n == OP_MULH) && req_src2[XLEN-1];
   assign neg_d = sgn1 ^ sgn2;

   // The most negative value negates to itself, which is its correct magnitude
   assign mag1 = sgn1 ? -opa_eff : opa_eff;
   assign mag2 = sgn2 ? -opb_eff : opb_eff;

   assign accept = (state_q == S_IDLE) && req_valid && !flush;

`ifdef YSYX_22041207_MUL_ZERO_BYPASS_EN
   assign bypass_hit = (opa_eff == '0) || (opb_eff == '0);
`else
   assign bypass_hit = 1'b0;
`endif

   ysyx_22041207_mul_fixup #(.XLEN(XLEN)) u_fixup (
      .prod (prod_q),
      .neg  (neg_q),
      .op   (op_q),
      .res  (fix_res)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; flush outranks every other event
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = bypass_hit ? S_OUT : S_ISSUE;
         S_ISSUE: if (flush) state_d = S_IDLE; else if (mul_ready) state_d = S_WAIT;
         S_WAIT:  if (flush) state_d = S_IDLE; else if (mul_out_valid) state_d = S_FIX;
         S_FIX:   state_d = flush ? S_IDLE : S_OUT;
         S_OUT:   if (flush || wb_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the current state
   always_comb begin
      req_ready = (state_q == S_IDLE);
      wb_valid  = (state_q == S_OUT);
      busy      = (state_q != S_IDLE);
      mul_valid = (state_q == S_ISSUE) && !flush && !rst;
      mul_flush = (state_q == S_ISSUE || state_q == S_WAIT) && flush && !rst;
   end

   // Datapath registers: operands on accept, product in WAIT, result in FIX
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= OP_MUL;
         rd_q      <= '0;
         neg_q     <= 1'b0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         prod_q    <= '0;
         wb_data_q <= '0;
         wb_rd_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
               op_q     <= op_n;
               rd_q     <= req_rd;
               neg_q    <= neg_d;
               mcand_q  <= mag1;
               mplier_q <= mag2;
               if (bypass_hit) begin
                  wb_data_q <= '0;
                  wb_rd_q   <= req_rd;
               end
            end
            S_WAIT: if (!flush && mul_out_valid) prod_q <= {mul_res_hi, mul_res_lo};
            S_FIX: if (!flush) begin
               wb_data_q <= fix_res;
               wb_rd_q   <= rd_q;
            end
            default: ;
         endcase
      end
   end

   assign mul_multiplicand = mcand_q;
   assign mul_multiplier   = mplier_q;
   assign wb_data          = wb_data_q;
   assign wb_rd            = wb_rd_q;

endmodule
